// File: rtl/inst_fetch_if.sv
// Handshake bundle between the fetch unit, instruction memory, execute redirect and decode.
interface inst_fetch_if #(
   parameter int XLEN = 32
);
   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_gnt_i;
   logic            imem_rvalid_i;
   logic [XLEN-1:0] imem_rdata_i;
   logic            redirect_i;
   logic [XLEN-1:0] redirect_pc_i;
   logic            inst_valid_o;
   logic            inst_ready_i;
   logic [XLEN-1:0] inst_o;
   logic [XLEN-1:0] inst_pc_o;
   logic [6:0]      opcode_o;
   logic            misalign_o;

   modport master (
      output imem_req_o, imem_addr_o,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
      input  redirect_i, redirect_pc_i,
      output inst_valid_o,
      input  inst_ready_i,
      output inst_o, inst_pc_o, opcode_o, misalign_o
   );

   modport slave (
      input  imem_req_o, imem_addr_o,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
      output redirect_i, redirect_pc_i,
      input  inst_valid_o,
      output inst_ready_i,
      input  inst_o, inst_pc_o, opcode_o, misalign_o
   );
endinterface

// File: rtl/inst_fetch.sv
// RV32I fetch front end: PC generation, single-outstanding memory request FSM,
// and a 2-entry prefetch FIFO feeding decode, with redirect flush/drop handling.
module inst_fetch #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int              BUF_DEPTH = 2
) (
   input logic         clk_i,
   input logic         rst_i,
   inst_fetch_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t          r_state;
   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_req_pc;
   logic            r_out;
   logic            r_drop;
   logic            r_misalign;
   logic            r_rd_ptr;
   logic [1:0]      r_count;
   logic [XLEN-1:0] r_buf_inst [BUF_DEPTH];
   logic [XLEN-1:0] r_buf_pc   [BUF_DEPTH];

   logic            w_req;
   logic            w_grant;
   logic            w_resp;
   logic            w_push;
   logic            w_pop;
   logic            w_valid;
   logic            w_wr_ptr;
   logic [XLEN-1:0] w_redir_pc;
   logic [XLEN-1:0] w_head_inst;

   // Never request while a response could land in a full buffer.
   assign w_req      = (r_state == S_REQ) && ((r_count + {1'b0, r_out}) < 2'd2);
   assign w_grant    = w_req && bus.imem_gnt_i;
   assign w_resp     = (r_state == S_WAIT) && bus.imem_rvalid_i;
   assign w_push     = w_resp && !r_drop && !bus.redirect_i;
   assign w_valid    = (r_count != 2'd0);
   assign w_pop      = w_valid && bus.inst_ready_i && !bus.redirect_i;
   assign w_wr_ptr   = r_rd_ptr ^ (r_count == 2'd1);
   assign w_redir_pc = {bus.redirect_pc_i[XLEN-1:2], 2'b00};
   assign w_head_inst = w_valid ? r_buf_inst[r_rd_ptr] : '0;

   assign bus.imem_req_o   = w_req;
   assign bus.imem_addr_o  = r_fetch_pc;
   assign bus.inst_valid_o = w_valid;
   assign bus.inst_o       = w_head_inst;
   assign bus.inst_pc_o    = w_valid ? r_buf_pc[r_rd_ptr] : '0;
   assign bus.opcode_o     = w_head_inst[6:0];
   assign bus.misalign_o   = r_misalign;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= RESET_PC;
         r_out      <= 1'b0;
         r_drop     <= 1'b0;
         r_misalign <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_count    <= 2'd0;
      end else begin
         r_misalign <= bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00);

         if (bus.redirect_i)
            r_fetch_pc <= w_redir_pc;
         else if (w_grant)
            r_fetch_pc <= r_fetch_pc + XLEN'(4);

         if (bus.redirect_i)
            r_count <= 2'd0;
         else
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
         if (w_pop)
            r_rd_ptr <= ~r_rd_ptr;

         case (r_state)
            S_IDLE: r_state <= S_REQ;
            S_REQ: begin
               if (w_grant) begin
                  r_state <= S_WAIT;
                  r_out   <= 1'b1;
                  r_drop  <= bus.redirect_i;
               end
            end
            S_WAIT: begin
               // A redirect coinciding with the response discards it directly, so no drop is left pending.
               if (bus.imem_rvalid_i) begin
                  r_state <= S_REQ;
                  r_out   <= 1'b0;
                  r_drop  <= 1'b0;
               end else if (bus.redirect_i) begin
                  r_drop <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_grant)
         r_req_pc <= r_fetch_pc;
      if (w_push) begin
         r_buf_inst[w_wr_ptr] <= bus.imem_rdata_i;
         r_buf_pc[w_wr_ptr]   <= r_req_pc;
      end
   end
endmodule

// File: tb/tb_inst_fetch.sv
// Randomized scoreboard bench for inst_fetch with a behavioural memory and fetch-stream model.
module tb_inst_fetch;
   localparam int          XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   inst_fetch_if #(.XLEN(XLEN)) bus ();

   inst_fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_pops  = 0;

   logic [31:0] exp_q [$];
   logic [31:0] grant_log [$];

   bit          mem_pend = 0;
   logic [31:0] mem_addr = '0;
   int          mem_wait = 0;
   int          lat_min  = 1;
   int          lat_max  = 1;
   int          gnt_pct  = 100;
   int          rdy_pct  = 100;
   bit          auto_rdy = 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic load_stream(input logic [31:0] start);
      exp_q.delete();
      for (int k = 0; k < 300; k++) exp_q.push_back(start + 32'(4 * k));
   endtask

   // Memory model + default stimulus; returns 1 time unit after the rising edge.
   task automatic step();
      bit          granted;
      bit          responded;
      logic [31:0] gaddr;
      @(negedge clk);
      granted   = bus.imem_req_o && bus.imem_gnt_i && !rst;
      responded = bus.imem_rvalid_i;
      gaddr     = bus.imem_addr_o;
      @(posedge clk);
      #1;
      if (rst) begin
         mem_pend = 0;
      end else begin
         if (responded) mem_pend = 0;
         if (granted) begin
            mem_pend = 1;
            mem_addr = gaddr;
            mem_wait = int'($urandom_range(lat_max - 1, lat_min - 1));
            grant_log.push_back(gaddr);
         end else if (mem_pend && mem_wait > 0) begin
            mem_wait--;
         end
      end
      bus.imem_rvalid_i = mem_pend && (mem_wait == 0) && !rst;
      bus.imem_rdata_i  = bus.imem_rvalid_i ? mem_word(mem_addr) : $urandom;
      bus.imem_gnt_i    = (int'($urandom_range(99, 0)) < gnt_pct);
      bus.redirect_i    = 1'b0;
      if (auto_rdy) bus.inst_ready_i = (int'($urandom_range(99, 0)) < rdy_pct);
   endtask

   task automatic do_redirect(input logic [31:0] tgt);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = tgt;
      load_stream({tgt[31:2], 2'b00});
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      bus.imem_rvalid_i = 1'b0;
      bus.redirect_i    = 1'b0;
      mem_pend = 0;
      load_stream(RESET_PC);
      grant_log.delete();
      step();
      step();
      rst = 1'b0;
   endtask

   // Monitor: fetch-address sequence, scoreboard pops, flush, hold and misalign rules.
   logic [31:0] m_exp_addr;
   bit          m_prev_redir, m_prev_mis, m_prev_hold;
   logic [31:0] m_prev_inst, m_prev_pc;
   int          m_idle;

   always @(negedge clk) begin
      logic [31:0] e;
      logic [31:0] w;
      if (rst) begin
         m_exp_addr   = RESET_PC;
         m_prev_redir = 0;
         m_prev_mis   = 0;
         m_prev_hold  = 0;
         m_idle       = 0;
      end else begin
         check("misalign", 32'(bus.misalign_o), 32'(m_prev_mis));
         if (m_prev_redir) check("flush_valid", 32'(bus.inst_valid_o), 32'd0);
         if (m_prev_hold) begin
            check("hold_valid", 32'(bus.inst_valid_o), 32'd1);
            check("hold_inst", bus.inst_o, m_prev_inst);
            check("hold_pc", bus.inst_pc_o, m_prev_pc);
         end
         if (bus.imem_req_o && bus.imem_gnt_i) begin
            check("fetch_addr", bus.imem_addr_o, m_exp_addr);
            m_exp_addr = m_exp_addr + 32'd4;
         end
         if (bus.redirect_i) m_exp_addr = {bus.redirect_pc_i[31:2], 2'b00};
         if (bus.inst_valid_o && bus.inst_ready_i && !bus.redirect_i) begin
            n_pops++;
            m_idle = 0;
            if (exp_q.size() == 0) begin
               check("stream_exhausted", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               w = mem_word(e);
               check("inst_pc", bus.inst_pc_o, e);
               check("inst", bus.inst_o, w);
               check("opcode", 32'(bus.opcode_o), 32'(w[6:0]));
            end
         end else if (!bus.inst_ready_i || bus.redirect_i) begin
            m_idle = 0;
         end else begin
            m_idle++;
            if (m_idle > 60) begin
               check("liveness", 32'(m_idle), 32'd60);
               m_idle = 0;
            end
         end
         m_prev_mis   = bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00);
         m_prev_redir = bus.redirect_i;
         m_prev_hold  = bus.inst_valid_o && !bus.inst_ready_i && !bus.redirect_i;
         m_prev_inst  = bus.inst_o;
         m_prev_pc    = bus.inst_pc_o;
      end
   end

   initial begin
      int gl;
      int p0;
      bit hit;
      bus.imem_gnt_i    = 1'b0;
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = '0;
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = '0;
      bus.inst_ready_i  = 1'b0;
      load_stream(RESET_PC);
      repeat (3) @(posedge clk);
      #1;
      check("rst_req", 32'(bus.imem_req_o), 32'd0);
      check("rst_valid", 32'(bus.inst_valid_o), 32'd0);
      check("rst_misalign", 32'(bus.misalign_o), 32'd0);
      check("rst_inst", bus.inst_o, 32'd0);
      check("rst_pc", bus.inst_pc_o, 32'd0);
      check("rst_opcode", 32'(bus.opcode_o), 32'd0);

      // Sequential fetch, 1-cycle memory, decode always ready
      rst = 1'b0;
      repeat (20) step();
      check("seq_grants", 32'(grant_log.size() >= 4), 32'd1);
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         check("seq_addr", grant_log[i], 32'(4 * i));

      // Decode stall fills the buffer and stops fetch
      apply_reset();
      auto_rdy = 0;
      bus.inst_ready_i = 1'b0;
      repeat (10) step();
      check("stall_valid", 32'(bus.inst_valid_o), 32'd1);
      check("stall_pc", bus.inst_pc_o, 32'h0);
      check("stall_inst", bus.inst_o, 32'hA5A5_0000);
      check("stall_req", 32'(bus.imem_req_o), 32'd0);
      check("stall_grants", 32'(grant_log.size()), 32'd2);
      auto_rdy = 1;
      repeat (20) step();
      check("resume_grants", 32'(grant_log.size() >= 3), 32'd1);
      if (grant_log.size() >= 3) check("resume_addr", grant_log[2], 32'h8);

      // Redirect while 0x8 is in WAIT (3-cycle memory)
      apply_reset();
      lat_min = 3; lat_max = 3;
      hit = 0;
      for (int i = 0; i < 60 && !hit; i++) begin
         step();
         if (grant_log.size() >= 3) hit = 1;
      end
      check("wait8_reached", 32'(hit), 32'd1);
      check("wait8_addr", grant_log.size() >= 3 ? grant_log[2] : 32'hFFFF_FFFF, 32'h8);
      p0 = n_pops;
      do_redirect(32'h100);
      repeat (30) step();
      check("redir100_progress", 32'(n_pops > p0), 32'd1);

      // Misaligned redirect target
      lat_min = 1; lat_max = 1;
      do_redirect(32'h202);
      step();
      check("misalign_pulse", 32'(bus.misalign_o), 32'd1);
      gl = grant_log.size();
      step();
      check("misalign_end", 32'(bus.misalign_o), 32'd0);
      repeat (20) step();
      check("mis_grant_cnt", 32'(grant_log.size() > gl), 32'd1);
      if (grant_log.size() > gl) check("mis_next_addr", grant_log[gl], 32'h200);

      // Redirect coinciding with the grant for 0xC
      apply_reset();
      hit = 0;
      for (int i = 0; i < 60 && !hit; i++) begin
         step();
         if (bus.imem_req_o && bus.imem_gnt_i && bus.imem_addr_o == 32'hC) hit = 1;
      end
      check("gnt_c_reached", 32'(hit), 32'd1);
      do_redirect(32'h40);
      step();
      gl = grant_log.size();
      check("gnt_c_logged", gl > 0 ? grant_log[gl - 1] : 32'hFFFF_FFFF, 32'hC);
      repeat (20) step();
      check("gnt_c_next_cnt", 32'(grant_log.size() > gl), 32'd1);
      if (grant_log.size() > gl) check("gnt_c_next_addr", grant_log[gl], 32'h40);

      // Redirect in the same cycle as rvalid
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         step();
         if (bus.imem_rvalid_i) hit = 1;
      end
      check("rv_reached", 32'(hit), 32'd1);
      p0 = n_pops;
      do_redirect(32'h80);
      repeat (20) step();
      check("rv_progress", 32'(n_pops > p0), 32'd1);

      // Asynchronous reset during WAIT with one buffered entry
      apply_reset();
      auto_rdy = 0;
      bus.inst_ready_i = 1'b0;
      lat_min = 3; lat_max = 3;
      hit = 0;
      for (int i = 0; i < 60 && !hit; i++) begin
         step();
         if (grant_log.size() >= 2) hit = 1;
      end
      check("mid_reached", 32'(hit), 32'd1);
      check("mid_valid", 32'(bus.inst_valid_o), 32'd1);
      #2;
      rst = 1'b1;
      bus.imem_rvalid_i = 1'b0;
      load_stream(RESET_PC);
      #1;
      check("arst_valid", 32'(bus.inst_valid_o), 32'd0);
      check("arst_inst", bus.inst_o, 32'd0);
      check("arst_pc", bus.inst_pc_o, 32'd0);
      check("arst_opcode", 32'(bus.opcode_o), 32'd0);
      check("arst_req", 32'(bus.imem_req_o), 32'd0);
      grant_log.delete();
      mem_pend = 0;
      step();
      step();
      rst = 1'b0;
      auto_rdy = 1;
      lat_min = 1; lat_max = 1;
      repeat (20) step();
      check("arst_grant_cnt", 32'(grant_log.size() > 0), 32'd1);
      if (grant_log.size() > 0) check("arst_first_addr", grant_log[0], RESET_PC);

      // Randomized traffic with wrap-around and random redirects
      lat_min = 1; lat_max = 3;
      gnt_pct = 60; rdy_pct = 75;
      do_redirect(32'hFFFF_FFF8);
      for (int i = 0; i < 1500; i++) begin
         step();
         if ($urandom_range(99, 0) < 3) do_redirect(32'($urandom_range(1023, 0)));
      end
      repeat (10) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch front end for the single-cycle/multicycle RV32I core.
- Produces the instruction stream that the main control decoder consumes: PC generation, instruction-memory request handshake, and a 2-entry prefetch buffer.
- Presents instruction word, PC and opcode (bits [6:0]) to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute.

Parameters:
- XLEN, 32, address and data width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, prefetch buffer entries; fixed at 2, any other value is unsupported.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- imem_req_o  out  1  request valid to instruction memory.
- imem_addr_o  out  XLEN  request address, word-aligned.
- imem_gnt_i  in  1  memory accepts request this cycle.
- imem_rvalid_i  in  1  read data valid; exactly one response per granted request, in order, at least 1 cycle after grant.
- imem_rdata_i  in  XLEN  read data.
- redirect_i  in  1  pipeline redirect (taken branch/jump).
- redirect_pc_i  in  XLEN  redirect target.
- inst_valid_o  out  1  buffer head valid.
- inst_ready_i  in  1  decode consumes head.
- inst_o  out  XLEN  head instruction word.
- inst_pc_o  out  XLEN  head PC.
- opcode_o  out  7  inst_o[6:0], routed to the control decoder.
- misalign_o  out  1  one-cycle pulse: redirect target with bits [1:0] != 0.

Behaviour:
- Reset (async assert, sync-safe release):
  - fetch_pc = RESET_PC.
  - Buffer empty, count = 0.
  - Outstanding = 0, drop = 0.
  - imem_req_o = 0, inst_valid_o = 0, misalign_o = 0.
  - inst_o, inst_pc_o, opcode_o = 0.
- FSM states:
  - IDLE: one cycle after reset release, no request. Next state is REQ.
  - REQ: drive imem_req_o = 1, imem_addr_o = fetch_pc, only when count + outstanding < 2.
    - Hold req/addr stable until imem_gnt_i.
    - On grant: outstanding = 1, fetch_pc += 4 (wraps modulo 2^XLEN), go to WAIT.
  - WAIT: imem_req_o = 0.
    - On imem_rvalid_i with drop = 0: push {rdata, pc_of_request} into the buffer.
    - On imem_rvalid_i with drop = 1: discard the data and clear drop.
    - Either way: outstanding = 0, go to REQ.
- Single outstanding request maximum. Best-case fetch throughput is 1 instruction per 2 cycles with a 1-cycle memory.
- Buffer:
  - FIFO; head drives inst_o, inst_pc_o, opcode_o.
  - inst_valid_o = (count != 0).
  - Pop when inst_valid_o && inst_ready_i.
  - Push and pop in the same cycle leave count unchanged.
  - Full (count = 2): no new request issued. A response never arrives when full, by the issue rule.
  - Outputs hold stable while inst_valid_o && !inst_ready_i.
- Redirect (highest priority, same cycle):
  - Buffer flushed: count = 0, inst_valid_o = 0 next cycle; a simultaneous pop is ignored.
  - fetch_pc = {redirect_pc_i[XLEN-1:2], 2'b00}.
  - misalign_o pulses if redirect_pc_i[1:0] != 0.
  - Redirect in REQ with grant in the same cycle: the granted request becomes in-flight with drop = 1.
  - Redirect in REQ without grant: request is withdrawn and re-issued next cycle at the new PC. This is the only permitted address change while req = 1.
  - Redirect in WAIT: drop = 1. If rvalid arrives in the same cycle, that data is discarded and drop stays 0.
  - Back-to-back redirects: the last one wins; drop never exceeds one pending response.
- Reset mid-transaction: all state cleared immediately. The memory is required to be reset by the same rst_i, so no stale response arrives.
- No latency from grant to push beyond memory latency: data is pushed in the rvalid cycle, visible on inst_o the next cycle.

Test Plan:
- Reset, memory returns mem[a] = a ^ 32'hA5A5_0000 with 1-cycle latency, decode always ready -> addresses 0, 4, 8, 12 requested in order; inst_pc_o / inst_o sequence 0/0xA5A5_0000, 4/0xA5A5_0004, …; opcode_o = inst_o[6:0].
- Decode stalls (ready = 0) for 10 cycles -> exactly 2 entries buffered, imem_req_o stays 0 after the second response, inst_o stable; on release PCs 0, 4 pop, then fetch resumes at 8.
- Redirect to 0x100 while request to 0x8 is in WAIT -> response for 0x8 dropped; next visible inst_pc_o = 0x100; buffer flushed the cycle after redirect.
- Redirect to 0x202 -> misalign_o pulses for 1 cycle, next fetch address 0x200.
- Redirect coinciding with imem_gnt_i for 0xC -> 0xC response dropped, next request 0x40 (target); redirect and rvalid in the same cycle -> data discarded, no extra drop.
- Assert rst_i during WAIT with 1 buffered entry -> outputs 0 immediately; after release the first request is to RESET_PC.
